carrd_wb_arbiter: RTL and testbench

Writeback arbiter for the Carrd vector coprocessor. It sits between the functional units (VALU, VMUL, VLOAD, VSLDU, VRED) and the single register-file write port. It holds each unit's finished result in a one-entry buffer and grants the write port to one buffered result per cycle, round-robin. It replaces the priority if/else writeback selection and lets several units complete in the same cycle without losing results.

---
 rtl/carrd_wb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_carrd_wb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/carrd_wb_arbiter.sv
// Writeback arbiter for the Carrd vector coprocessor: one-entry result buffer per
// functional unit, round-robin grant of the single register-file write port.
module carrd_wb_arbiter #(
    parameter int unsigned NUM_UNITS = 5,
    parameter int unsigned VLEN      = 512,
    parameter int unsigned RED_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_UNITS-1:0]     done_vec,
    input  logic [5*NUM_UNITS-1:0]   req_vd,
    input  logic [2*NUM_UNITS-1:0]   req_sel_dest,
    input  logic [VLEN-1:0]          result_valu,
    input  logic [VLEN-1:0]          result_vmul,
    input  logic [VLEN-1:0]          result_vload,
    input  logic [VLEN-1:0]          result_vsldu,
    input  logic [RED_W-1:0]         result_vred,
    output logic [NUM_UNITS-1:0]     unit_busy,
    output logic                     v_reg_wr_en,
    output logic                     x_reg_wr_en,
    output logic [4:0]               reg_wr_addr,
    output logic [127:0]             reg_wr_data,
    output logic [127:0]             reg_wr_data_2,
    output logic [127:0]             reg_wr_data_3,
    output logic [127:0]             reg_wr_data_4,
    output logic [2:0]               wb_unit,
    output logic                     overflow_err
);

    logic [VLEN-1:0]      unit_result [NUM_UNITS];
    logic [NUM_UNITS-1:0] sel_ok;

    logic [NUM_UNITS-1:0] buf_valid_q, buf_valid_d;
    logic [4:0]           buf_vd_q    [NUM_UNITS];
    logic [4:0]           buf_vd_d    [NUM_UNITS];
    logic [1:0]           buf_sel_q   [NUM_UNITS];
    logic [1:0]           buf_sel_d   [NUM_UNITS];
    logic [VLEN-1:0]      buf_data_q  [NUM_UNITS];
    logic [VLEN-1:0]      buf_data_d  [NUM_UNITS];

    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic                 v_wr_q, v_wr_d;
    logic                 x_wr_q, x_wr_d;
    logic [4:0]           wr_addr_q, wr_addr_d;
    logic [VLEN-1:0]      wr_data_q, wr_data_d;
    logic [2:0]           wb_unit_q, wb_unit_d;
    logic                 overflow_q, overflow_d;

    logic [NUM_UNITS-1:0] grant;
    logic                 grant_any;
    logic [2:0]           grant_idx;
    logic [3:0]           scan_idx;

    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            unit_result[i] = '0;
        end
        unit_result[0] = result_valu;
        unit_result[1] = result_vmul;
        unit_result[2] = result_vload;
        unit_result[3] = result_vsldu;
        unit_result[4] = {{(VLEN-RED_W){1'b0}}, result_vred};
        for (int i = 0; i < NUM_UNITS; i++) begin
            sel_ok[i] = (req_sel_dest[2*i +: 2] == 2'd1) || (req_sel_dest[2*i +: 2] == 2'd2);
        end
    end

    // Scan rr_ptr, rr_ptr+1, ... (mod NUM_UNITS); first valid buffer wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + 4'(k);
            if (scan_idx >= 4'(NUM_UNITS)) begin
                scan_idx = scan_idx - 4'(NUM_UNITS);
            end
            if (!grant_any && buf_valid_q[scan_idx[2:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx[2:0];
            end
        end
        for (int i = 0; i < NUM_UNITS; i++) begin
            grant[i] = grant_any && (grant_idx == 3'(i));
        end
    end

    assign unit_busy = buf_valid_q & ~grant;

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_vd_d    = buf_vd_q;
        buf_sel_d   = buf_sel_q;
        buf_data_d  = buf_data_q;
        overflow_d  = overflow_q;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (grant[i]) begin
                buf_valid_d[i] = 1'b0;
            end
            if (done_vec[i] && sel_ok[i]) begin
                // A granted buffer frees at this edge, so it can take the new result.
                if (!buf_valid_q[i] || grant[i]) begin
                    buf_valid_d[i] = 1'b1;
                    buf_vd_d[i]    = req_vd[5*i +: 5];
                    buf_sel_d[i]   = req_sel_dest[2*i +: 2];
                    buf_data_d[i]  = unit_result[i];
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end

        rr_ptr_d  = rr_ptr_q;
        v_wr_d    = 1'b0;
        x_wr_d    = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wb_unit_d = wb_unit_q;
        if (grant_any) begin
            rr_ptr_d  = (grant_idx == 3'(NUM_UNITS - 1)) ? 3'd0 : grant_idx + 3'd1;
            v_wr_d    = (buf_sel_q[grant_idx] == 2'd1);
            x_wr_d    = (buf_sel_q[grant_idx] == 2'd2);
            wr_addr_d = buf_vd_q[grant_idx];
            wr_data_d = buf_data_q[grant_idx];
            wb_unit_d = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= '0;
            rr_ptr_q    <= '0;
            v_wr_q      <= 1'b0;
            x_wr_q      <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wb_unit_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            v_wr_q      <= v_wr_d;
            x_wr_q      <= x_wr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wb_unit_q   <= wb_unit_d;
            overflow_q  <= overflow_d;
        end
    end

    // Payload is only meaningful while buf_valid is set, so it needs no reset.
    always_ff @(posedge clk) begin
        buf_vd_q   <= buf_vd_d;
        buf_sel_q  <= buf_sel_d;
        buf_data_q <= buf_data_d;
    end

    assign v_reg_wr_en   = v_wr_q;
    assign x_reg_wr_en   = x_wr_q;
    assign reg_wr_addr   = wr_addr_q;
    assign reg_wr_data   = wr_data_q[127:0];
    assign reg_wr_data_2 = wr_data_q[255:128];
    assign reg_wr_data_3 = wr_data_q[383:256];
    assign reg_wr_data_4 = wr_data_q[511:384];
    assign wb_unit       = wb_unit_q;
    assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_carrd_wb_arbiter.sv
// Bench for carrd_wb_arbiter: per-cycle vector table for strobes/grants/busy plus a
// per-unit scoreboard that matches every register-file write against captured results.
module tb_carrd_wb_arbiter;

    logic         clk;
    logic         rst;
    logic [4:0]   done_vec;
    logic [24:0]  req_vd;
    logic [9:0]   req_sel_dest;
    logic [511:0] result_valu, result_vmul, result_vload, result_vsldu;
    logic [31:0]  result_vred;
    logic [4:0]   unit_busy;
    logic         v_reg_wr_en, x_reg_wr_en;
    logic [4:0]   reg_wr_addr;
    logic [127:0] reg_wr_data, reg_wr_data_2, reg_wr_data_3, reg_wr_data_4;
    logic [2:0]   wb_unit;
    logic         overflow_err;

    carrd_wb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .done_vec      (done_vec),
        .req_vd        (req_vd),
        .req_sel_dest  (req_sel_dest),
        .result_valu   (result_valu),
        .result_vmul   (result_vmul),
        .result_vload  (result_vload),
        .result_vsldu  (result_vsldu),
        .result_vred   (result_vred),
        .unit_busy     (unit_busy),
        .v_reg_wr_en   (v_reg_wr_en),
        .x_reg_wr_en   (x_reg_wr_en),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .reg_wr_data_2 (reg_wr_data_2),
        .reg_wr_data_3 (reg_wr_data_3),
        .reg_wr_data_4 (reg_wr_data_4),
        .wb_unit       (wb_unit),
        .overflow_err  (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  done;
        logic [24:0] vd;
        logic [9:0]  sel;
        logic [7:0]  tag;
        logic [4:0]  cap;   // units whose pulse this cycle must be captured
        logic        v_en;
        logic        x_en;
        logic [2:0]  wbu;
        logic [4:0]  busy;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [2:0]   unit;
        logic [4:0]   addr;
        logic         v;
        logic         x;
        logic [511:0] data;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   row     = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [511:0] unit_data(input int u, input logic [7:0] tag);
        logic [31:0] w;
        if (u == 4) return {480'd0, 16'hDEAD, 8'hBE, tag};
        w = {8'hA5, 5'd0, 3'(u), tag, 8'h3C};
        return {16{w}};
    endfunction

    function automatic vec_t mk(input logic r, input logic [4:0] d, input logic [24:0] vd,
                                input logic [9:0] sel, input logic [7:0] tag,
                                input logic [4:0] cap, input logic v, input logic x,
                                input logic [2:0] wbu, input logic [4:0] busy, input logic ovf);
        vec_t t;
        t.rst = r; t.done = d; t.vd = vd; t.sel = sel; t.tag = tag; t.cap = cap;
        t.v_en = v; t.x_en = x; t.wbu = wbu; t.busy = busy; t.ovf = ovf;
        return t;
    endfunction

    function automatic vec_t idle(input logic v, input logic [2:0] wbu, input logic [4:0] busy,
                                  input logic ovf);
        return mk(1'b0, 5'd0, 25'd0, 10'd0, 8'h00, 5'd0, v, 1'b0, wbu, busy, ovf);
    endfunction

    // Drive one cycle of stimulus, clock it, and check the post-edge outputs.
    task automatic tick(input vec_t t);
        exp_t e;
        rst          = t.rst;
        done_vec     = t.done;
        req_vd       = t.vd;
        req_sel_dest = t.sel;
        result_valu  = unit_data(0, t.tag);
        result_vmul  = unit_data(1, t.tag);
        result_vload = unit_data(2, t.tag);
        result_vsldu = unit_data(3, t.tag);
        result_vred  = {16'hDEAD, 8'hBE, t.tag};
        for (int i = 0; i < 5; i++) begin
            if (t.cap[i]) begin
                e.unit = 3'(i);
                e.addr = t.vd[5*i +: 5];
                e.v    = (t.sel[2*i +: 2] == 2'd1);
                e.x    = (t.sel[2*i +: 2] == 2'd2);
                e.data = unit_data(i, t.tag);
                sbq.push_back(e);
            end
        end
        @(posedge clk);
        if (t.rst) sbq.delete();
        #1;
        check($sformatf("v_reg_wr_en row %0d", row), 512'(v_reg_wr_en), 512'(t.v_en));
        check($sformatf("x_reg_wr_en row %0d", row), 512'(x_reg_wr_en), 512'(t.x_en));
        check($sformatf("wb_unit row %0d", row), 512'(wb_unit), 512'(t.wbu));
        check($sformatf("unit_busy row %0d", row), 512'(unit_busy), 512'(t.busy));
        check($sformatf("overflow_err row %0d", row), 512'(overflow_err), 512'(t.ovf));
        if (t.rst) begin
            check($sformatf("reg_wr_addr reset row %0d", row), 512'(reg_wr_addr), 512'd0);
            check($sformatf("reg_wr_data reset row %0d", row),
                  {reg_wr_data_4, reg_wr_data_3, reg_wr_data_2, reg_wr_data}, 512'd0);
        end
        row++;
    endtask

    // Every strobe must match the oldest outstanding result of the unit being written.
    always @(negedge clk) begin
        int idx;
        if (v_reg_wr_en || x_reg_wr_en) begin
            idx = -1;
            for (int k = 0; k < sbq.size(); k++) begin
                if (idx < 0 && sbq[k].unit == wb_unit) idx = k;
            end
            check($sformatf("write_expected unit %0d", wb_unit), 512'(idx >= 0), 512'd1);
            if (idx >= 0) begin
                check("wb_addr", 512'(reg_wr_addr), 512'(sbq[idx].addr));
                check("wb_strobes", 512'({v_reg_wr_en, x_reg_wr_en}),
                      512'({sbq[idx].v, sbq[idx].x}));
                check("wb_data", {reg_wr_data_4, reg_wr_data_3, reg_wr_data_2, reg_wr_data},
                      sbq[idx].data);
                sbq.delete(idx);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; done_vec = '0; req_vd = '0; req_sel_dest = '0;
        result_valu = '0; result_vmul = '0; result_vload = '0; result_vsldu = '0;
        result_vred = '0;

        tbl.push_back(mk(1'b1, 5'd0, 25'd0, 10'd0, 8'h00, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0));
        tbl.push_back(mk(1'b1, 5'd0, 25'd0, 10'd0, 8'h00, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0));
        // All five units complete together, rr_ptr=0: drain 0..4
        tbl.push_back(mk(1'b0, 5'b11111, {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 10'b01_01_01_01_01,
                         8'hB0, 5'b11111, 1'b0, 1'b0, 3'd0, 5'b11110, 1'b0));
        tbl.push_back(idle(1'b1, 3'd0, 5'b11100, 1'b0));
        tbl.push_back(idle(1'b1, 3'd1, 5'b11000, 1'b0));
        tbl.push_back(idle(1'b1, 3'd2, 5'b10000, 1'b0));
        tbl.push_back(idle(1'b1, 3'd3, 5'b00000, 1'b0));
        tbl.push_back(idle(1'b1, 3'd4, 5'b00000, 1'b0));
        tbl.push_back(idle(1'b0, 3'd4, 5'b00000, 1'b0));
        // Single VALU result, vd=3
        tbl.push_back(mk(1'b0, 5'b00001, {20'd0, 5'd3}, 10'b00_00_00_00_01, 8'hA5, 5'b00001,
                         1'b0, 1'b0, 3'd4, 5'd0, 1'b0));
        tbl.push_back(idle(1'b1, 3'd0, 5'd0, 1'b0));
        tbl.push_back(idle(1'b0, 3'd0, 5'd0, 1'b0));
        // Fairness: VALU streams via free/load, VMUL pulses once (rr_ptr=1)
        tbl.push_back(mk(1'b0, 5'b00001, {20'd0, 5'd8}, 10'b00_00_00_00_01, 8'hC1, 5'b00001,
                         1'b0, 1'b0, 3'd0, 5'd0, 1'b0));
        tbl.push_back(mk(1'b0, 5'b00011, {15'd0, 5'd9, 5'd8}, 10'b00_00_00_01_01, 8'hC2,
                         5'b00011, 1'b1, 1'b0, 3'd0, 5'b00001, 1'b0));
        tbl.push_back(idle(1'b1, 3'd1, 5'd0, 1'b0));
        tbl.push_back(mk(1'b0, 5'b00001, {20'd0, 5'd8}, 10'b00_00_00_00_01, 8'hC4, 5'b00001,
                         1'b1, 1'b0, 3'd0, 5'd0, 1'b0));
        tbl.push_back(idle(1'b1, 3'd0, 5'd0, 1'b0));
        tbl.push_back(idle(1'b0, 3'd0, 5'd0, 1'b0));
        // VRED scalar write, then sel=0 and sel=3 pulses that must not write
        tbl.push_back(mk(1'b0, 5'b10000, {5'd7, 20'd0}, {2'd2, 8'd0}, 8'hEF, 5'b10000,
                         1'b0, 1'b0, 3'd0, 5'd0, 1'b0));
        tbl.push_back(mk(1'b0, 5'b10000, {5'd7, 20'd0}, 10'd0, 8'h11, 5'd0,
                         1'b0, 1'b1, 3'd4, 5'd0, 1'b0));
        tbl.push_back(mk(1'b0, 5'b00100, {10'd0, 5'd6, 10'd0}, {4'd0, 2'd3, 4'd0}, 8'h22, 5'd0,
                         1'b0, 1'b0, 3'd4, 5'd0, 1'b0));
        tbl.push_back(idle(1'b0, 3'd4, 5'd0, 1'b0));

        foreach (tbl[r]) tick(tbl[r]);

        // Overflow: VSLDU pulses again while held behind units 0..2 (rr_ptr=0)
        tick(mk(1'b0, 5'b01111, {5'd0, 5'd13, 5'd12, 5'd11, 5'd10}, 10'b00_01_01_01_01, 8'hE1,
                5'b01111, 1'b0, 1'b0, 3'd4, 5'b01110, 1'b0));
        tick(mk(1'b0, 5'b01000, {5'd0, 5'd14, 15'd0}, 10'b00_01_00_00_00, 8'hE2, 5'd0,
                1'b1, 1'b0, 3'd0, 5'b01100, 1'b1));
        tick(idle(1'b1, 3'd1, 5'b01000, 1'b1));
        tick(idle(1'b1, 3'd2, 5'd0, 1'b1));
        tick(idle(1'b1, 3'd3, 5'd0, 1'b1));
        tick(idle(1'b0, 3'd3, 5'd0, 1'b1));

        // Reset with three pending buffers (rr_ptr=4); the pulse in the reset cycle is lost
        tick(mk(1'b0, 5'b01110, {5'd0, 5'd23, 5'd22, 5'd21, 5'd0}, 10'b00_01_01_01_00, 8'hF1,
                5'b01110, 1'b0, 1'b0, 3'd3, 5'b01100, 1'b1));
        tick(mk(1'b1, 5'b00001, {20'd0, 5'd31}, 10'b00_00_00_00_01, 8'hF2, 5'd0,
                1'b0, 1'b0, 3'd0, 5'd0, 1'b0));
        // VRED and VALU together: VALU must win, proving rr_ptr restarted at 0
        tick(mk(1'b0, 5'b10001, {5'd30, 15'd0, 5'd31}, 10'b01_00_00_00_01, 8'hF3, 5'b10001,
                1'b0, 1'b0, 3'd0, 5'b10000, 1'b0));
        tick(idle(1'b1, 3'd0, 5'd0, 1'b0));
        tick(idle(1'b1, 3'd4, 5'd0, 1'b0));
        tick(idle(1'b0, 3'd4, 5'd0, 1'b0));
        tick(idle(1'b0, 3'd4, 5'd0, 1'b0));

        check("scoreboard_drained", 512'(sbq.size()), 512'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
